irq_encoder_8to3: RTL and testbench

- Sequential 8-to-3 priority encoder: the encoding end of the 3-to-8 decoder path.
- Captures eight request lines into sticky pending bits and presents the highest-priority pending index as a 3-bit code with a valid/ack handshake.
- Sits in front of a consumer, e.g. a decoder or interrupt handler, that services one index at a time.

---
 rtl/irq_encoder_8to3.sv | 134 +++++++++++++
 tb/tb_irq_encoder_8to3.sv | 183 ++++++++++++++++++
 2 files changed

// File: rtl/irq_encoder_8to3.sv
// Sequential 8-to-3 priority encoder. Sticky pending bits feed a registered
// code/valid presentation that the consumer retires one index at a time via ack.
module irq_encoder_8to3 #(
  parameter bit HIGH_FIRST = 1'b1
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       enable,
  input  logic [7:0] req,
  input  logic       ack,
  output logic [2:0] code,
  output logic       valid,
  output logic [7:0] pending,
  output logic       ovf
);

  typedef enum logic {
    IDLE    = 1'b0,
    PRESENT = 1'b1
  } state_t;

  state_t     state_r;
  state_t     state_next_s;
  logic [7:0] pending_r;
  logic [7:0] pending_next_s;
  logic [2:0] code_r;
  logic [2:0] code_next_s;
  logic       valid_r;
  logic       valid_next_s;
  logic       ovf_r;
  logic       ovf_next_s;
  logic [7:0] set_s;
  logic [7:0] clr_s;

  // Highest set index when HIGH_FIRST, else lowest; zero input yields 0.
  function automatic logic [2:0] prio(input logic [7:0] vec);
    logic [2:0] idx;
    idx = 3'd0;
    if (HIGH_FIRST) begin
      for (int i = 0; i < 8; i++) begin
        if (vec[i]) idx = 3'(i);
      end
    end else begin
      for (int i = 7; i >= 0; i--) begin
        if (vec[i]) idx = 3'(i);
      end
    end
    return idx;
  endfunction

  function automatic logic [7:0] onehot(input logic [2:0] idx);
    return 8'd1 << idx;
  endfunction

  // Pending update: set dominates clear, so a re-request of the acked index survives.
  always_comb begin
    set_s          = 8'h00;
    clr_s          = 8'h00;
    if (enable) begin
      set_s = req;
    end else begin
      set_s = 8'h00;
    end
    if (ack && valid_r) begin
      clr_s = onehot(code_r);
    end else begin
      clr_s = 8'h00;
    end
    pending_next_s = (pending_r & ~clr_s) | set_s;
    ovf_next_s     = |(set_s & pending_r & ~clr_s);
  end

  // Presentation FSM: no preemption, back-to-back handoff on ack.
  always_comb begin
    state_next_s = state_r;
    code_next_s  = code_r;
    valid_next_s = valid_r;
    case (state_r)
      IDLE: begin
        if (pending_next_s != 8'h00) begin
          state_next_s = PRESENT;
          valid_next_s = 1'b1;
          code_next_s  = prio(pending_next_s);
        end else begin
          state_next_s = IDLE;
          valid_next_s = 1'b0;
        end
      end
      PRESENT: begin
        if (ack) begin
          if (pending_next_s != 8'h00) begin
            state_next_s = PRESENT;
            valid_next_s = 1'b1;
            code_next_s  = prio(pending_next_s);
          end else begin
            state_next_s = IDLE;
            valid_next_s = 1'b0;
          end
        end else begin
          state_next_s = PRESENT;
          valid_next_s = 1'b1;
        end
      end
      default: begin
        state_next_s = IDLE;
        valid_next_s = 1'b0;
        code_next_s  = 3'd0;
      end
    endcase
  end

  // State and output registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r   <= IDLE;
      pending_r <= 8'h00;
      code_r    <= 3'd0;
      valid_r   <= 1'b0;
      ovf_r     <= 1'b0;
    end else begin
      state_r   <= state_next_s;
      pending_r <= pending_next_s;
      code_r    <= code_next_s;
      valid_r   <= valid_next_s;
      ovf_r     <= ovf_next_s;
    end
  end

  assign code    = code_r;
  assign valid   = valid_r;
  assign pending = pending_r;
  assign ovf     = ovf_r;

endmodule

// File: tb/tb_irq_encoder_8to3.sv
// Bench for irq_encoder_8to3: HIGH_FIRST=1 and HIGH_FIRST=0 instances share
// stimulus and are compared each cycle against an arithmetic reference model.
module tb_irq_encoder_8to3;

  logic       clk;
  logic       rst;
  logic       enable;
  logic [7:0] req;
  logic       ack;
  logic [2:0] code_h, code_l;
  logic       valid_h, valid_l;
  logic [7:0] pending_h, pending_l;
  logic       ovf_h, ovf_l;

  int checks = 0;
  int errors = 0;

  int m_pend [2];
  int m_code [2];
  bit m_valid[2];
  bit m_ovf  [2];

  irq_encoder_8to3 #(.HIGH_FIRST(1'b1)) dut_h (
    .clk(clk), .rst(rst), .enable(enable), .req(req), .ack(ack),
    .code(code_h), .valid(valid_h), .pending(pending_h), .ovf(ovf_h)
  );

  irq_encoder_8to3 #(.HIGH_FIRST(1'b0)) dut_l (
    .clk(clk), .rst(rst), .enable(enable), .req(req), .ack(ack),
    .code(code_l), .valid(valid_l), .pending(pending_l), .ovf(ovf_l)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic check(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Highest set bit via log2, lowest via isolating the least significant one.
  function automatic int pick(input int v, input int hf);
    if (hf == 1) return $clog2(v + 1) - 1;
    return $clog2(v & -v);
  endfunction

  task automatic model_edge();
    for (int k = 0; k < 2; k++) begin
      int s, c, np;
      if (rst) begin
        m_pend[k] = 0; m_code[k] = 0; m_valid[k] = 0; m_ovf[k] = 0;
      end else begin
        s  = enable ? int'(req) : 0;
        c  = (ack && m_valid[k]) ? (1 << m_code[k]) : 0;
        np = (m_pend[k] & ~c) | s;
        m_ovf[k] = ((s & m_pend[k] & ~c) != 0);
        if (!m_valid[k] || ack) begin
          if (np != 0) begin
            m_valid[k] = 1;
            m_code[k]  = pick(np, (k == 0) ? 1 : 0);
          end else begin
            m_valid[k] = 0;
          end
        end
        m_pend[k] = np;
      end
    end
  endtask

  task automatic step();
    @(posedge clk);
    model_edge();
    #1;
    check("code_h",    {5'd0, code_h},    8'(m_code[0]));
    check("valid_h",   {7'd0, valid_h},   {7'd0, m_valid[0]});
    check("pending_h", pending_h,         8'(m_pend[0]));
    check("ovf_h",     {7'd0, ovf_h},     {7'd0, m_ovf[0]});
    check("code_l",    {5'd0, code_l},    8'(m_code[1]));
    check("valid_l",   {7'd0, valid_l},   {7'd0, m_valid[1]});
    check("pending_l", pending_l,         8'(m_pend[1]));
    check("ovf_l",     {7'd0, ovf_l},     {7'd0, m_ovf[1]});
  endtask

  task automatic drive(input logic r, input logic en, input logic [7:0] rq, input logic a);
    rst = r; enable = en; req = rq; ack = a;
    step();
  endtask

  initial begin
    rst = 1'b1; enable = 1'b0; req = 8'h00; ack = 1'b0;

    // Reset then idle.
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    drive(1'b1, 1'b0, 8'h00, 1'b0);
    check("rst_code",  {5'd0, code_h},  8'd0);
    check("rst_valid", {7'd0, valid_h}, 8'd0);
    check("rst_pend",  pending_h,       8'h00);
    check("rst_ovf",   {7'd0, ovf_h},   8'd0);

    // Single request, then ack.
    drive(1'b0, 1'b1, 8'h20, 1'b0);
    check("single_code",  {5'd0, code_h},  8'd5);
    check("single_valid", {7'd0, valid_h}, 8'd1);
    check("single_pend",  pending_h,       8'h20);
    drive(1'b0, 1'b1, 8'h00, 1'b1);
    check("single_ack_valid", {7'd0, valid_h}, 8'd0);
    check("single_ack_pend",  pending_h,       8'h00);

    // Priority, no preemption.
    drive(1'b0, 1'b1, 8'h05, 1'b0);
    check("prio_code",   {5'd0, code_h}, 8'd2);
    check("prio_code_l", {5'd0, code_l}, 8'd0);
    drive(1'b0, 1'b1, 8'h80, 1'b0);
    check("nopre_code", {5'd0, code_h}, 8'd2);
    check("nopre_pend", pending_h,      8'h85);
    drive(1'b0, 1'b1, 8'h00, 1'b1);
    check("ack1_code", {5'd0, code_h}, 8'd7);
    drive(1'b0, 1'b1, 8'h00, 1'b1);
    check("ack2_code", {5'd0, code_h}, 8'd0);
    drive(1'b0, 1'b1, 8'h00, 1'b1);
    check("ack3_valid", {7'd0, valid_h}, 8'd0);

    // Enable gating and full drain.
    drive(1'b0, 1'b0, 8'hFF, 1'b0);
    check("gate_valid", {7'd0, valid_h}, 8'd0);
    check("gate_pend",  pending_h,       8'h00);
    drive(1'b0, 1'b1, 8'hFF, 1'b0);
    check("all_pend", pending_h,      8'hFF);
    check("all_code", {5'd0, code_h}, 8'd7);
    for (int i = 1; i <= 8; i++) begin
      drive(1'b0, 1'b1, 8'h00, 1'b1);
      if (i < 8) check("drain_code", {5'd0, code_h}, 8'(7 - i));
      else       check("drain_valid", {7'd0, valid_h}, 8'd0);
    end

    // Overflow and set-wins-over-clear.
    drive(1'b0, 1'b1, 8'h10, 1'b0);
    check("ovf_pre", {7'd0, ovf_h}, 8'd0);
    drive(1'b0, 1'b1, 8'h10, 1'b0);
    check("ovf_pulse", {7'd0, ovf_h}, 8'd1);
    drive(1'b0, 1'b1, 8'h10, 1'b1);
    check("setwin_pend",  pending_h,       8'h10);
    check("setwin_valid", {7'd0, valid_h}, 8'd1);
    check("setwin_code",  {5'd0, code_h},  8'd4);
    check("setwin_ovf",   {7'd0, ovf_h},   8'd0);
    drive(1'b0, 1'b1, 8'h00, 1'b1);

    // Reset mid-operation.
    drive(1'b0, 1'b1, 8'h3C, 1'b0);
    check("mid_pend", pending_h, 8'h3C);
    drive(1'b1, 1'b1, 8'hFF, 1'b1);
    check("midrst_pend",  pending_h,       8'h00);
    check("midrst_valid", {7'd0, valid_h}, 8'd0);
    check("midrst_code",  {5'd0, code_h},  8'd0);
    check("midrst_ovf",   {7'd0, ovf_h},   8'd0);

    // Low-first ordering.
    drive(1'b0, 1'b1, 8'h05, 1'b0);
    check("lo_code0", {5'd0, code_l}, 8'd0);
    drive(1'b0, 1'b1, 8'h00, 1'b1);
    check("lo_code2", {5'd0, code_l}, 8'd2);
    drive(1'b0, 1'b1, 8'h00, 1'b1);

    // Randomized traffic.
    for (int n = 0; n < 400; n++) begin
      logic [7:0] r;
      r = 8'($urandom) & 8'($urandom) & 8'($urandom);
      drive(($urandom_range(0, 99) == 0) ? 1'b1 : 1'b0,
            ($urandom_range(0, 9) != 0) ? 1'b1 : 1'b0,
            r,
            1'($urandom));
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
